uart_bus_master: RTL

- Debug/bootload bus initiator: parses command frames arriving as bytes from the UART rx FIFO and issues single-word reads/writes on the same word-addressed memory bus the CPU drives.
- Returns responses through the UART tx FIFO.
- Sits between the uart block and the bus mux. While busy=1, the system arbitrates the bus to this block, e.g. to load RAM before releasing the CPU.

---
 rtl/uart_bus_pkg.sv | 8 +
 rtl/uart_bus_master.sv | 90 +++++++++
 2 files changed

// File: rtl/uart_bus_pkg.sv
// uart_bus_pkg: command/response codes and FSM states shared by the UART bus master
package uart_bus_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, CAPT, RESP, ACK, NAK} state_t;
endpackage

// File: rtl/uart_bus_master.sv
// uart_bus_master: turns UART command frames into single-word bus reads/writes and replies over UART
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1200000,
  parameter int CNT_W          = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_pop,
  output logic [7:0]  tx_data,
  input  logic        tx_full,
  output logic        tx_push,
  output logic [29:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        re,
  output logic [3:0]  we,
  input  logic        mem_ready,
  output logic        busy
);
  state_t state, state_n;
  logic is_wr, rxing, txing, tmo;
  logic [1:0] idx;
  logic [29:0] addr_sh;
  logic [31:0] data_sh, rsp;
  logic [CNT_W-1:0] cnt;
  assign rxing = state inside {IDLE, ADDR, DATA};
  assign txing = state inside {RESP, ACK, NAK};
  assign rx_pop = reset && rxing && !rx_empty;
  assign tx_push = reset && txing && !tx_full;
  assign tmo = TIMEOUT_CYCLES != 0 && state inside {ADDR, DATA} && cnt == CNT_W'(TIMEOUT_CYCLES);
  assign re = state == REQ && !is_wr;
  assign we = {4{state == REQ && is_wr}};
  assign busy = state != IDLE;
  assign addr = addr_sh;
  assign wdata = data_sh;
  assign tx_data = state == RESP ? rsp[{idx, 3'b000} +: 8] :
                   state == ACK  ? RSP_ACK :
                   state == NAK  ? RSP_NAK : 8'h00;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (rx_pop) state_n = (rx_data == CMD_WRITE || rx_data == CMD_READ) ? ADDR : NAK;
      ADDR: if (rx_pop) state_n = idx == 2'd3 ? (is_wr ? DATA : REQ) : ADDR;
            else if (tmo) state_n = IDLE;
      DATA: if (rx_pop) state_n = idx == 2'd3 ? REQ : DATA;
            else if (tmo) state_n = IDLE;
      REQ:  if (mem_ready) state_n = is_wr ? ACK : CAPT;
      CAPT: state_n = RESP;
      RESP: if (tx_push && idx == 2'd3) state_n = IDLE;
      ACK, NAK: if (tx_push) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Shifting 30 bits drops byte-address bits [1:0] as the last byte moves through
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      is_wr   <= 1'b0;
      idx     <= '0;
      addr_sh <= '0;
      data_sh <= '0;
      rsp     <= '0;
      cnt     <= '0;
    end else begin
      state <= state_n;
      cnt   <= (rx_pop || !(state inside {ADDR, DATA})) ? '0 : cnt + CNT_W'(1);
      if (state == IDLE && rx_pop) begin
        is_wr <= rx_data == CMD_WRITE;
        idx   <= '0;
      end
      if (state == ADDR && rx_pop) begin
        addr_sh <= {rx_data, addr_sh[29:8]};
        idx     <= idx + 2'd1;
      end
      if (state == DATA && rx_pop) begin
        data_sh <= {rx_data, data_sh[31:8]};
        idx     <= idx + 2'd1;
      end
      if (state == CAPT) begin
        rsp <= rdata;
        idx <= '0;
      end
      if (state == RESP && tx_push) idx <= idx + 2'd1;
    end
  end
endmodule
